// File: rtl/read_iface_pkg.sv
// Shared definitions for the sample-buffer read responder: FSM encoding,
// default burst length and the byte-lane order used when serialising words.
package read_iface_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_EMPTY = 2'd1,
    FETCH      = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam int BURST_WORDS_DEF = 16;

  // Serial position p takes byte lane LANE_ORDER[2p+1:2p]: little-endian.
  localparam logic [7:0] LANE_ORDER = 8'b11_10_01_00;

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] pos);
    logic [1:0] lane;
    lane = LANE_ORDER[2*pos +: 2];
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO, depth 2^FIFO_AW, registered dout updated the cycle after rd_en.
// rd_en while empty is ignored; the writer guarantees it never writes when full.
module sync_word_fifo #(
  parameter int FIFO_AW = 4,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0]    mem [2**FIFO_AW];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
      if (rd_en && !empty) begin
        dout   <= mem[rd_ptr[FIFO_AW-1:0]];
        rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/bram_read_responder.sv
// Answers a level read request with a BURST_WORDS fetch from sample memory, serialised LE to bytes.
// rd_done after BURST_WORDS+3 cycles when drained; a new fetch waits until every byte is popped.
module bram_read_responder
  import read_iface_pkg::*;
#(
  parameter int AW          = 28,
  parameter int BURST_WORDS = BURST_WORDS_DEF,
  parameter int FIFO_AW     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_req,
  input  logic [29:0]   rd_addr,
  output logic          rd_done,
  output logic          busy,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  input  logic          fifo_rd_en,
  output logic          fifo_empty,
  output logic [7:0]    fifo_dout
);

  localparam int ICW = $clog2(BURST_WORDS + 1);
  localparam int WCW = $clog2(BURST_WORDS);

  state_t         state;
  logic           rd_req_q;
  logic [AW-1:0]  base_addr;
  logic [ICW-1:0] issue_cnt;
  logic [WCW-1:0] wr_cnt;
  logic           rd_pend;

  logic           wf_rd_en;
  logic [31:0]    wf_dout;
  logic           wf_empty;
  logic           wf_full;

  logic           ser_vld;
  logic [1:0]     byte_idx;
  logic           byte_pop;
  logic           drained;

  logic           unused_addr_bits;
  assign unused_addr_bits = ^rd_addr[1:0];

  // rd_pend marks the cycle mem_rdata is valid; it doubles as the FIFO write strobe.
  sync_word_fifo #(
    .FIFO_AW (FIFO_AW),
    .DW      (32)
  ) u_word_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (rd_pend),
    .din   (mem_rdata),
    .rd_en (wf_rd_en),
    .dout  (wf_dout),
    .empty (wf_empty),
    .full  (wf_full)
  );

  assign drained = wf_empty && !ser_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_done   <= 1'b0;
      busy      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      base_addr <= '0;
      issue_cnt <= '0;
      wr_cnt    <= '0;
      rd_pend   <= 1'b0;
      rd_req_q  <= 1'b0;
    end else begin
      rd_req_q <= rd_req;
      rd_pend  <= mem_rd_en;
      case (state)
        IDLE: begin
          if (rd_req && !rd_req_q) begin
            base_addr <= rd_addr[AW+1:2];
            busy      <= 1'b1;
            state     <= WAIT_EMPTY;
          end
        end
        WAIT_EMPTY: begin
          if (drained) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= base_addr;
            issue_cnt <= ICW'(1);
            wr_cnt    <= '0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (issue_cnt != ICW'(BURST_WORDS)) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= mem_addr + AW'(1);
            issue_cnt <= issue_cnt + ICW'(1);
          end else begin
            mem_rd_en <= 1'b0;
          end
          // A request dropped mid-burst still loads everything, it just skips DONE.
          if (rd_pend) begin
            wr_cnt <= wr_cnt + WCW'(1);
            if (wr_cnt == WCW'(BURST_WORDS - 1)) begin
              if (rd_req) begin
                rd_done <= 1'b1;
                state   <= DONE;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
        end
        DONE: begin
          if (!rd_req) begin
            rd_done <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The serialiser reads bytes straight out of the word FIFO's output register and
  // refills it on the same cycle the last byte leaves, so bytes stream back to back.
  assign byte_pop   = fifo_rd_en && ser_vld;
  assign wf_rd_en   = !wf_empty && (!ser_vld || (byte_pop && byte_idx == 2'd3));
  assign fifo_empty = !ser_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      ser_vld   <= 1'b0;
      byte_idx  <= 2'd0;
      fifo_dout <= 8'd0;
    end else begin
      if (byte_pop) begin
        fifo_dout <= lane_byte(wf_dout, byte_idx);
        byte_idx  <= byte_idx + 2'd1;
      end
      if (wf_rd_en) ser_vld <= 1'b1;
      else if (byte_pop && byte_idx == 2'd3) ser_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(rd_pend && wf_full));
  end

endmodule
